seven_segment_driver: RTL



---
 rtl/soc_pkg.sv | 36 +++
 rtl/hex_to_7seg.sv | 12 +
 rtl/seven_segment_driver.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/soc_pkg.sv
// Shared SOC definitions: IO address of the seven-segment peripheral,
// CTRL register layout and the hex-digit segment patterns.
package soc_pkg;

   localparam logic [31:0] SEVEN_SEG_ADDR = 32'h0000_0400;

   localparam int VALUE_LSB   = 0;
   localparam int VALUE_WIDTH = 8;
   localparam int ENABLE_BIT  = 8;

   // Active-high patterns in gfedcba order; entry N is the glyph for hex digit N.
   localparam logic [15:0][6:0] HEX_PATTERNS = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   typedef enum logic {
      ST_SHOW  = 1'b0,
      ST_BLANK = 1'b1
   } disp_state_t;

   function automatic logic [31:0] ctrl_word(input logic [VALUE_WIDTH-1:0] value,
                                             input logic                   enable);
      logic [31:0] word;
      word                             = '0;
      word[VALUE_LSB +: VALUE_WIDTH]   = value;
      word[ENABLE_BIT]                 = enable;
      return word;
   endfunction

   function automatic logic [6:0] drive_polarity(input logic [6:0] pattern,
                                                 input logic       active_low);
      return active_low ? ~pattern : pattern;
   endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to seven-segment decoder, active-high output;
// the board polarity is applied by the caller.
module hex_to_7seg
   import soc_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] pattern
);

   assign pattern = HEX_PATTERNS[nibble];

endmodule

// File: rtl/seven_segment_driver.sv
// Memory-mapped dual-digit seven-segment driver: CTRL register on the IO bus,
// frame-aligned shadow copy, and a SHOW/BLANK multiplexer with registered outputs.
module seven_segment_driver
   import soc_pkg::*;
#(
   parameter int REFRESH_DIV  = 4096,
   parameter int BLANK_CYCLES = 16,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        sel,
   input  logic        wstrb,
   input  logic        rstrb,
   input  logic [31:0] wdata,
   input  logic [3:0]  wmask,
   output logic [31:0] rdata,
   output logic [6:0]  segment_display,
   output logic        segment_select
);

   localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   logic [VALUE_WIDTH-1:0] value_reg, value_next;
   logic                   enable_reg, enable_next;
   logic [31:0]            rdata_reg, rdata_next;
   logic [VALUE_WIDTH-1:0] shadow_val_reg, shadow_val_next;
   logic                   shadow_en_reg, shadow_en_next;
   disp_state_t            state_reg, state_next;
   logic [CNT_W-1:0]       counter_reg, counter_next;
   logic                   digit_reg, digit_next;
   logic                   select_reg;
   logic [6:0]             display_reg, display_next;
   logic                   shadow_load;
   logic [3:0]             nibble;
   logic [6:0]             glyph;
   logic                   bus_unused;

   // Upper data bits and the upper byte enables have no destination in CTRL.
   assign bus_unused = ^{wdata[31:9], wmask[3:2]};

   // ---------------- bus side: CTRL write and registered read ----------------
   always_comb begin
      value_next  = value_reg;
      enable_next = enable_reg;
      rdata_next  = rdata_reg;
      if (sel && rstrb) begin
         rdata_next = ctrl_word(value_reg, enable_reg);
      end
      if (sel && wstrb) begin
         if (wmask[0]) value_next  = wdata[VALUE_LSB +: VALUE_WIDTH];
         if (wmask[1]) enable_next = wdata[ENABLE_BIT];
      end
   end

   // ---------------- display multiplexer ----------------
   always_comb begin
      state_next   = state_reg;
      counter_next = counter_reg + CNT_W'(1);
      digit_next   = digit_reg;
      shadow_load  = 1'b0;
      case (state_reg)
         ST_SHOW: begin
            if (counter_reg == SHOW_LAST) begin
               counter_next = '0;
               state_next   = ST_BLANK;
            end
         end
         ST_BLANK: begin
            if (counter_reg == BLANK_LAST) begin
               counter_next = '0;
               digit_next   = ~digit_reg;
               state_next   = ST_SHOW;
               // Leaving digit 1 means entering digit 0: a new frame starts.
               shadow_load  = digit_reg;
            end
         end
         default: begin
            counter_next = '0;
            state_next   = ST_BLANK;
         end
      endcase
   end

   always_comb begin
      shadow_val_next = shadow_val_reg;
      shadow_en_next  = shadow_en_reg;
      if (shadow_load) begin
         shadow_val_next = value_reg;
         shadow_en_next  = enable_reg;
      end
   end

   // Outputs are decoded from the next-state view so that the registered
   // segments and digit select switch together with the FSM.
   assign nibble = digit_next ? shadow_val_next[7:4] : shadow_val_next[3:0];

   hex_to_7seg u_hex_to_7seg (
      .nibble  (nibble),
      .pattern (glyph)
   );

   always_comb begin
      display_next = drive_polarity(7'b0, ACTIVE_LOW);
      if (state_next == ST_SHOW && shadow_en_next) begin
         display_next = drive_polarity(glyph, ACTIVE_LOW);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         value_reg      <= '0;
         enable_reg     <= 1'b0;
         rdata_reg      <= '0;
         shadow_val_reg <= '0;
         shadow_en_reg  <= 1'b0;
         state_reg      <= ST_BLANK;
         counter_reg    <= '0;
         digit_reg      <= 1'b1;
         select_reg     <= 1'b1;
         display_reg    <= drive_polarity(7'b0, ACTIVE_LOW);
      end else begin
         value_reg      <= value_next;
         enable_reg     <= enable_next;
         rdata_reg      <= rdata_next;
         shadow_val_reg <= shadow_val_next;
         shadow_en_reg  <= shadow_en_next;
         state_reg      <= state_next;
         counter_reg    <= counter_next;
         digit_reg      <= digit_next;
         select_reg     <= digit_next;
         display_reg    <= display_next;
      end
   end

   assign rdata           = rdata_reg;
   assign segment_display = display_reg;
   assign segment_select  = select_reg;

endmodule
